// File: rtl/scr1_rst_seq_pkg.sv
`default_nettype none
// ============================================================================
//  Module   : scr1_rst_seq_pkg
//  Brief    : Shared types, counter-width helpers and parameter limits for the
//             multi-hart reset sequencer.
//  Revision : 1.0 - initial release
// ============================================================================
package scr1_rst_seq_pkg;

  // Per-channel sequencing states
  typedef enum logic [1:0] {
    RUN    = 2'd0,
    DRAIN  = 2'd1,
    HOLD   = 2'd2,
    SETTLE = 2'd3
  } type_scr1_rst_seq_state_e;

  // Legal parameter ranges
  localparam int SCR1_RST_SEQ_HARTS_MIN    = 1;
  localparam int SCR1_RST_SEQ_HARTS_MAX    = 8;
  localparam int SCR1_RST_SEQ_QLFY_DLY_MIN = 1;
  localparam int SCR1_RST_SEQ_RST_HOLD_MIN = 1;

  // Default timing
  localparam int SCR1_RST_SEQ_QLFY_DLY_DEF = 2;
  localparam int SCR1_RST_SEQ_RST_HOLD_DEF = 4;

  function automatic int scr1_rst_seq_max(input int a, input int b);
    return (a > b) ? a : b;
  endfunction

  // The shared down-counter must hold the larger of the two reload values
  function automatic int scr1_rst_seq_cnt_w(input int qlfy_dly, input int rst_hold);
    return $clog2(scr1_rst_seq_max(qlfy_dly, rst_hold) + 1);
  endfunction

endpackage : scr1_rst_seq_pkg
`default_nettype wire

// File: rtl/scr1_rst_seq_ch.sv
`default_nettype none
// ============================================================================
//  Module   : scr1_rst_seq_ch
//  Brief    : One reset channel: drain -> hold -> settle sequencer with a
//             shared down-counter, registered rst_n / RDC qualifier outputs
//             and a status bit (sticky when SCR1_RST_SEQ_STICKY_STATUS_EN is
//             defined, otherwise a plain "not running" flag).
//  Revision : 1.0 - initial release
// ============================================================================
module scr1_rst_seq_ch
  import scr1_rst_seq_pkg::*;
#(
  parameter int QLFY_DLY     = SCR1_RST_SEQ_QLFY_DLY_DEF,
  parameter int RST_HOLD_CYC = SCR1_RST_SEQ_RST_HOLD_DEF
) (
  input  logic clk,
  input  logic rst,
  input  logic i_req,
  input  logic i_status_clr,
  output logic o_rst_n,
  output logic o_qlfy,
  output logic o_busy,
  output logic o_status
);

  localparam int c_cnt_w = scr1_rst_seq_cnt_w(QLFY_DLY, RST_HOLD_CYC);

  localparam logic [c_cnt_w-1:0] c_qlfy_ld = c_cnt_w'(QLFY_DLY - 1);
  localparam logic [c_cnt_w-1:0] c_hold_ld = c_cnt_w'(RST_HOLD_CYC - 1);
  localparam logic [c_cnt_w-1:0] c_cnt_one = c_cnt_w'(1);

  localparam logic [1:0] c_st_run    = RUN;
  localparam logic [1:0] c_st_drain  = DRAIN;
  localparam logic [1:0] c_st_hold   = HOLD;
  localparam logic [1:0] c_st_settle = SETTLE;

  logic [1:0]         r_state;
  logic [1:0]         w_state_nxt;
  logic [c_cnt_w-1:0] r_cnt;
  logic [c_cnt_w-1:0] w_cnt_nxt;
  logic               w_cnt_zero;
  logic               r_rst_n;
  logic               r_qlfy;
  logic               r_busy;

  assign w_cnt_zero = (r_cnt == '0);

  // Next-state and counter reload/decrement
  always_comb begin
    w_state_nxt = r_state;
    w_cnt_nxt   = r_cnt;
    case (r_state)
      c_st_run: begin
        if (i_req) begin
          w_state_nxt = c_st_drain;
          w_cnt_nxt   = c_qlfy_ld;
        end
      end
      c_st_drain: begin
        // A request dropping here does not abort: the sequence is latched
        if (w_cnt_zero) begin
          w_state_nxt = c_st_hold;
          w_cnt_nxt   = c_hold_ld;
        end else begin
          w_cnt_nxt = r_cnt - c_cnt_one;
        end
      end
      c_st_hold: begin
        // A live request stretches the hold beyond the minimum
        if (w_cnt_zero) begin
          if (!i_req) begin
            w_state_nxt = c_st_settle;
            w_cnt_nxt   = c_qlfy_ld;
          end
        end else begin
          w_cnt_nxt = r_cnt - c_cnt_one;
        end
      end
      c_st_settle: begin
        // Qualifier is still low, so a new request can re-enter HOLD directly
        if (i_req) begin
          w_state_nxt = c_st_hold;
          w_cnt_nxt   = c_hold_ld;
        end else if (w_cnt_zero) begin
          w_state_nxt = c_st_run;
        end else begin
          w_cnt_nxt = r_cnt - c_cnt_one;
        end
      end
      default: begin
        w_state_nxt = c_st_hold;
        w_cnt_nxt   = c_hold_ld;
      end
    endcase
  end

  // State, counter and registered outputs decoded from the next state
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= c_st_hold;
      r_cnt   <= c_hold_ld;
      r_rst_n <= 1'b0;
      r_qlfy  <= 1'b0;
      r_busy  <= 1'b1;
    end else begin
      r_state <= w_state_nxt;
      r_cnt   <= w_cnt_nxt;
      r_rst_n <= (w_state_nxt != c_st_hold);
      r_qlfy  <= (w_state_nxt == c_st_run);
      r_busy  <= (w_state_nxt != c_st_run);
    end
  end

`ifdef SCR1_RST_SEQ_STICKY_STATUS_EN
  logic r_sticky;
  logic w_hold_entry;

  assign w_hold_entry = (w_state_nxt == c_st_hold) && (r_state != c_st_hold);

  // Sticky status: set on HOLD entry, cleared only while running; set wins
  always_ff @(posedge clk) begin
    if (rst) begin
      r_sticky <= 1'b1;
    end else if (w_hold_entry) begin
      r_sticky <= 1'b1;
    end else if (i_status_clr && (r_state == c_st_run)) begin
      r_sticky <= 1'b0;
    end
  end

  assign o_status = r_sticky;
`else
  logic w_unused_status_clr;

  assign w_unused_status_clr = i_status_clr;
  assign o_status            = r_busy;
`endif

  assign o_rst_n = r_rst_n;
  assign o_qlfy  = r_qlfy;
  assign o_busy  = r_busy;

endmodule : scr1_rst_seq_ch
`default_nettype wire

// File: rtl/scr1_rst_seq_mc.sv
`default_nettype none
// ============================================================================
//  Module   : scr1_rst_seq_mc
//  Brief    : Multi-hart reset sequencer. Channel 0 drives the system reset
//             domain, channel i+1 drives hart i; the system request fans out
//             to every hart channel. Optional macro:
//             SCR1_RST_SEQ_STICKY_STATUS_EN - sticky per-hart reset status.
//  Revision : 1.0 - initial release
// ============================================================================
module scr1_rst_seq_mc
  import scr1_rst_seq_pkg::*;
#(
  parameter int NUM_HARTS    = 2,
  parameter int QLFY_DLY     = SCR1_RST_SEQ_QLFY_DLY_DEF,
  parameter int RST_HOLD_CYC = SCR1_RST_SEQ_RST_HOLD_DEF
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 sys_rst_req_i,
  input  logic [NUM_HARTS-1:0] hart_rst_req_i,
  input  logic [NUM_HARTS-1:0] status_clr_i,
  output logic                 sys_rst_n_o,
  output logic                 sys_rdc_qlfy_o,
  output logic [NUM_HARTS-1:0] core_rst_n_o,
  output logic [NUM_HARTS-1:0] core_rdc_qlfy_o,
  output logic [NUM_HARTS-1:0] core_rst_status_o,
  output logic                 busy_o
);

  localparam int c_num_ch = NUM_HARTS + 1;

  // Elaboration-time parameter range checks
  if ((NUM_HARTS < SCR1_RST_SEQ_HARTS_MIN) || (NUM_HARTS > SCR1_RST_SEQ_HARTS_MAX)) begin : g_bad_num_harts
    $error("scr1_rst_seq_mc: NUM_HARTS out of range");
  end
  if (QLFY_DLY < SCR1_RST_SEQ_QLFY_DLY_MIN) begin : g_bad_qlfy_dly
    $error("scr1_rst_seq_mc: QLFY_DLY out of range");
  end
  if (RST_HOLD_CYC < SCR1_RST_SEQ_RST_HOLD_MIN) begin : g_bad_rst_hold
    $error("scr1_rst_seq_mc: RST_HOLD_CYC out of range");
  end

  logic [c_num_ch-1:0] w_req;
  logic [c_num_ch-1:0] w_clr;
  logic [c_num_ch-1:0] w_rst_n;
  logic [c_num_ch-1:0] w_qlfy;
  logic [c_num_ch-1:0] w_busy;
  logic [c_num_ch-1:0] w_status;
  logic                w_unused_sys_status;

  // System request is folded into every hart request
  assign w_req = {hart_rst_req_i | {NUM_HARTS{sys_rst_req_i}}, sys_rst_req_i};
  assign w_clr = {status_clr_i, 1'b0};

  for (genvar gi = 0; gi < c_num_ch; gi++) begin : g_ch
    scr1_rst_seq_ch #(
      .QLFY_DLY     (QLFY_DLY),
      .RST_HOLD_CYC (RST_HOLD_CYC)
    ) u_ch (
      .clk          (clk),
      .rst          (rst),
      .i_req        (w_req[gi]),
      .i_status_clr (w_clr[gi]),
      .o_rst_n      (w_rst_n[gi]),
      .o_qlfy       (w_qlfy[gi]),
      .o_busy       (w_busy[gi]),
      .o_status     (w_status[gi])
    );
  end

  assign sys_rst_n_o         = w_rst_n[0];
  assign sys_rdc_qlfy_o      = w_qlfy[0];
  assign core_rst_n_o        = w_rst_n[c_num_ch-1:1];
  assign core_rdc_qlfy_o     = w_qlfy[c_num_ch-1:1];
  assign core_rst_status_o   = w_status[c_num_ch-1:1];
  assign w_unused_sys_status = w_status[0];

  // Per-channel busy flags are registered; the top only merges them
  assign busy_o = |w_busy;

endmodule : scr1_rst_seq_mc
`default_nettype wire

// File: tb/tb_scr1_rst_seq_mc.sv
`default_nettype none
// ============================================================================
//  Module   : tb_scr1_rst_seq_mc
//  Brief    : Self-checking bench for scr1_rst_seq_mc. A timeline model tracks,
//             per channel, the edge at which reset went (or will go) low and
//             the edge at which it was released, and derives every output
//             from those timestamps.
//  Revision : 1.0 - initial release
// ============================================================================
module tb_scr1_rst_seq_mc;

  localparam int NH = 2;
  localparam int Q  = 2;
  localparam int H  = 4;
  localparam int NC = NH + 1;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          sys_rst_req_i = 1'b0;
  logic [NH-1:0] hart_rst_req_i = '0;
  logic [NH-1:0] status_clr_i = '0;
  logic          sys_rst_n_o;
  logic          sys_rdc_qlfy_o;
  logic [NH-1:0] core_rst_n_o;
  logic [NH-1:0] core_rdc_qlfy_o;
  logic [NH-1:0] core_rst_status_o;
  logic          busy_o;

  int n_checks = 0;
  int n_fail   = 0;
  int cyc      = 0;

  // Timeline model: active = sequence in progress; t_lo = edge rst_n goes low;
  // t_rel = edge rst_n was released (-1 while not yet released).
  bit m_active[NC];
  int m_tlo[NC];
  int m_trel[NC];
  bit m_stat[NC];

  scr1_rst_seq_mc #(
    .NUM_HARTS    (NH),
    .QLFY_DLY     (Q),
    .RST_HOLD_CYC (H)
  ) dut (
    .clk               (clk),
    .rst               (rst),
    .sys_rst_req_i     (sys_rst_req_i),
    .hart_rst_req_i    (hart_rst_req_i),
    .status_clr_i      (status_clr_i),
    .sys_rst_n_o       (sys_rst_n_o),
    .sys_rdc_qlfy_o    (sys_rdc_qlfy_o),
    .core_rst_n_o      (core_rst_n_o),
    .core_rdc_qlfy_o   (core_rdc_qlfy_o),
    .core_rst_status_o (core_rst_status_o),
    .busy_o            (busy_o)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h (cycle %0d)", tag, act, exp, cyc);
    end
  endtask

  function automatic bit in_reset(input int c, input int e);
    return m_active[c] && (m_trel[c] < 0) && (e >= m_tlo[c]);
  endfunction

  // Advance the model by one clock edge with the inputs sampled at that edge
  task automatic model_step(input bit r, input bit s, input bit [NH-1:0] h, input bit [NH-1:0] clr);
    int  e;
    bit  req, was_rst, was_idle, now_rst, cl;
    cyc++;
    e = cyc;
    for (int c = 0; c < NC; c++) begin
      req      = (c == 0) ? s : (h[c-1] | s);
      cl       = (c == 0) ? 1'b0 : clr[c-1];
      was_rst  = in_reset(c, e - 1);
      was_idle = !m_active[c];
      if (r) begin
        m_active[c] = 1'b1;
        m_tlo[c]    = e;
        m_trel[c]   = -1;
      end else if (!m_active[c]) begin
        if (req) begin
          m_active[c] = 1'b1;
          m_tlo[c]    = e + Q;
          m_trel[c]   = -1;
        end
      end else if (m_trel[c] < 0) begin
        if ((e >= m_tlo[c] + H) && !req) m_trel[c] = e;
      end else begin
        if (req) begin
          m_tlo[c]  = e;
          m_trel[c] = -1;
        end else if (e == m_trel[c] + Q) begin
          m_active[c] = 1'b0;
        end
      end
      now_rst = in_reset(c, e);
      if (r || (now_rst && !was_rst)) m_stat[c] = 1'b1;
      else if (cl && was_idle)        m_stat[c] = 1'b0;
    end
  endtask

  task automatic compare_outputs();
    logic [NH-1:0] e_rst_n, e_qlfy, e_stat;
    logic          e_busy;
    e_busy = 1'b0;
    for (int i = 0; i < NH; i++) begin
      e_rst_n[i] = !in_reset(i + 1, cyc);
      e_qlfy[i]  = !m_active[i + 1];
`ifdef SCR1_RST_SEQ_STICKY_STATUS_EN
      e_stat[i]  = m_stat[i + 1];
`else
      e_stat[i]  = m_active[i + 1];
`endif
    end
    for (int c = 0; c < NC; c++) e_busy |= m_active[c];
    check("sys_rst_n",   32'(sys_rst_n_o),       32'(!in_reset(0, cyc)));
    check("sys_qlfy",    32'(sys_rdc_qlfy_o),    32'(!m_active[0]));
    check("core_rst_n",  32'(core_rst_n_o),      32'(e_rst_n));
    check("core_qlfy",   32'(core_rdc_qlfy_o),   32'(e_qlfy));
    check("status",      32'(core_rst_status_o), 32'(e_stat));
    check("busy",        32'(busy_o),            32'(e_busy));
    // A qualifier may only be high while its reset is released
    check("qlfy_order",  32'({core_rdc_qlfy_o & ~core_rst_n_o, sys_rdc_qlfy_o & ~sys_rst_n_o}), 32'(0));
  endtask

  task automatic drive(input bit r, input bit s, input bit [NH-1:0] h, input bit [NH-1:0] clr);
    rst            = r;
    sys_rst_req_i  = s;
    hart_rst_req_i = h;
    status_clr_i   = clr;
    @(posedge clk);
    model_step(r, s, h, clr);
    #1;
    compare_outputs();
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) drive(1'b0, 1'b0, '0, '0);
  endtask

  int hold_left[NH];
  int sys_left;
  int rst_left;
  bit [NH-1:0] h_v;
  bit [NH-1:0] c_v;

  initial begin
    for (int c = 0; c < NC; c++) begin
      m_active[c] = 1'b1;
      m_tlo[c]    = 0;
      m_trel[c]   = -1;
      m_stat[c]   = 1'b1;
    end

    // Power-up
    for (int i = 0; i < 3; i++) drive(1'b1, 1'b0, '0, '0);
    idle(10);
    // Clear status while running
    drive(1'b0, 1'b0, '0, 2'b11);
    idle(2);
    // 1-cycle hart0 pulse, with a clear attempted during its HOLD
    drive(1'b0, 1'b0, 2'b01, '0);
    idle(3);
    drive(1'b0, 1'b0, '0, 2'b01);
    idle(10);
    drive(1'b0, 1'b0, '0, 2'b11);
    // hart1 request held for 10 cycles
    for (int i = 0; i < 10; i++) drive(1'b0, 1'b0, 2'b10, '0);
    idle(10);
    // System pulse: all channels in lockstep
    drive(1'b0, 1'b1, '0, '0);
    idle(12);
    // Re-request during SETTLE (release at +6, request at +7)
    drive(1'b0, 1'b0, 2'b01, '0);
    idle(6);
    drive(1'b0, 1'b0, 2'b01, '0);
    idle(12);
    // Reset mid-sequence
    drive(1'b0, 1'b1, 2'b11, '0);
    idle(3);
    drive(1'b1, 1'b0, '0, '0);
    idle(12);

    // Randomized traffic
    for (int i = 0; i < NH; i++) hold_left[i] = 0;
    sys_left = 0;
    rst_left = 0;
    for (int n = 0; n < 3000; n++) begin
      for (int i = 0; i < NH; i++) begin
        if (hold_left[i] == 0 && $urandom_range(0, 14) == 0) hold_left[i] = $urandom_range(1, 8);
        h_v[i] = (hold_left[i] != 0);
        if (hold_left[i] != 0) hold_left[i]--;
      end
      if (sys_left == 0 && $urandom_range(0, 59) == 0) sys_left = $urandom_range(1, 3);
      if (rst_left == 0 && $urandom_range(0, 399) == 0) rst_left = $urandom_range(1, 3);
      c_v = 2'($urandom_range(0, 3)) & {($urandom_range(0, 3) == 0), ($urandom_range(0, 3) == 0)};
      drive(rst_left != 0, sys_left != 0, h_v, c_v);
      if (sys_left != 0) sys_left--;
      if (rst_left != 0) rst_left--;
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule : tb_scr1_rst_seq_mc
`default_nettype wire

// File: doc/scr1_rst_seq_mc.md
Name: scr1_rst_seq_mc

Overview:
- Parametrised multi-hart reset sequencer with reset-domain-crossing (RDC) qualifiers, for multi-hart core tops.
- Drives one system reset domain plus NUM_HARTS core reset domains.
- Each domain runs its own sequence: drop qualifier, assert reset, release reset, raise qualifier.
- Compared with the single-hart reset/qualifier scheme it adds: per-hart channels, programmable drain, hold and settle timing, and system-reset fan-out to all harts.

Parameters:
- NUM_HARTS, 2, number of core reset channels (1..8).
- QLFY_DLY, 2, cycles the qualifier stays low before reset assertion and after reset release (>=1).
- RST_HOLD_CYC, 4, minimum cycles a reset stays asserted (>=1).

Ports:
- clk  in  1  core clock.
- rst  in  1  synchronous active-high reset.
- sys_rst_req_i  in  1  system reset request (level or 1-cycle pulse).
- hart_rst_req_i  in  NUM_HARTS  per-hart reset request.
- status_clr_i  in  NUM_HARTS  clear sticky status (optional feature only; ignored otherwise).
- sys_rst_n_o  out  1  system domain reset, active low.
- sys_rdc_qlfy_o  out  1  system domain RDC qualifier.
- core_rst_n_o  out  NUM_HARTS  per-hart reset, active low.
- core_rdc_qlfy_o  out  NUM_HARTS  per-hart RDC qualifier.
- core_rst_status_o  out  NUM_HARTS  channel not in RUN (or sticky, see Optional Feature).
- busy_o  out  1  OR of all channels not in RUN.

Behaviour:
- Channel layout: NUM_HARTS+1 identical channels. Channel 0 is sys; channel i+1 is hart i.
- Effective request: sys channel uses sys_rst_req_i. Hart i uses hart_rst_req_i[i] | sys_rst_req_i.
- All outputs are registered.
- FSM states per channel, with outputs:
  - RUN: rst_n=1, qlfy=1.
  - DRAIN: rst_n=1, qlfy=0.
  - HOLD: rst_n=0, qlfy=0.
  - SETTLE: rst_n=1, qlfy=0.
- Transitions:
  - RUN -> DRAIN when the effective request is sampled high; counter loads QLFY_DLY-1.
  - DRAIN -> HOLD when counter==0; counter loads RST_HOLD_CYC-1.
  - HOLD -> SETTLE when counter==0 and the request is low; counter loads QLFY_DLY-1. While the request stays high, remain in HOLD.
  - SETTLE -> RUN when counter==0.
  - A request seen in SETTLE -> HOLD directly, counter reloads RST_HOLD_CYC-1. The qualifier is already low, so no drain is needed.
- Counters decrement by 1 per cycle while in DRAIN, HOLD or SETTLE. Width is $clog2(max(QLFY_DLY,RST_HOLD_CYC)+1).
- Requests are edge-insensitive and latched by the FSM: a 1-cycle request completes the full sequence. A request deasserting during DRAIN does not abort the sequence.
- Timing from a request sampled at edge k:
  - qualifier low after edge k;
  - rst_n low after edge k+QLFY_DLY;
  - rst_n high after edge k+QLFY_DLY+max(RST_HOLD_CYC, request-high cycles after entering HOLD);
  - qualifier high QLFY_DLY edges after that.
- Reset (rst=1), all channels:
  - state HOLD, counter RST_HOLD_CYC-1;
  - rst_n_o=0, qlfy=0, busy_o=1, core_rst_status_o=all ones.
- rst asserted mid-sequence: immediately reinitialises per the reset values above, regardless of state.
- Simultaneous sys and hart requests: channels sequence independently. Hart channels in DRAIN ignore the new sys request; it is honoured in HOLD by extending the hold.
- Ordering guarantee: qlfy never rises while rst_n is low, and never goes 1 in the same cycle rst_n changes.

Optional Feature:
- Macro SCR1_RST_SEQ_STICKY_STATUS_EN.
- Defined: core_rst_status_o[i] sets on entry to HOLD. It clears only on status_clr_i[i] sampled high while the channel is in RUN; a set and a clear in the same cycle resolve to set. Reset value is 1.
- Undefined: core_rst_status_o[i] = (state != RUN). status_clr_i is unused.

Decomposition:
- Package scr1_rst_seq_pkg holds:
  - typedef enum logic [1:0] type_scr1_rst_seq_state_e {RUN, DRAIN, HOLD, SETTLE};
  - localparams for the counter-width computation;
  - parameter range check constants.
- Sub-module scr1_rst_seq_ch implements one channel: FSM, counter, rst_n/qlfy registers and the optional sticky bit. The top generate-loops NUM_HARTS+1 instances and ORs busy.

Test Plan (NUM_HARTS=2, QLFY_DLY=2, RST_HOLD_CYC=4):
- Power-up: rst high 3 cycles, then low -> all rst_n rise 4 edges later; all qlfy rise 2 edges after that; busy_o falls the same cycle the qualifiers rise.
- 1-cycle hart_rst_req_i=2'b01 -> hart0 qlfy low next cycle; rst_n0 low 2 edges later, for 4 cycles; qlfy0 high 2 edges after release. Hart1 and sys outputs unchanged throughout.
- hart_rst_req_i[1] held 10 cycles -> rst_n1 low until the first edge with the request sampled low, then settle 2 cycles.
- sys_rst_req_i pulse -> sys and both harts sequence in lockstep; core_rst_status_o=2'b11 during the sequence.
- Request re-asserted during SETTLE -> direct return to HOLD, 4 more reset cycles, no qualifier glitch high.
- With SCR1_RST_SEQ_STICKY_STATUS_EN: status stays 1 after RUN until status_clr_i pulse; clear during HOLD is ignored.
